getbits_ctrl: RTL and testbench

- Bit-reader front end for the MPEG decoder. Sits directly downstream of flushbuffer and drives its flush requests.
- Accepts "give me N bits" requests from header/VLC parsers and returns the top N bits of the flushbuffer window. It then commands flushbuffer to consume those bits.
- Requests wider than 16 bits are split into two flushes (16, then N-16). This keeps every flush well inside flushbuffer's 24-bit refill guarantee.
- After reset it primes flushbuffer, so the window is valid before the first request is accepted.

---
 rtl/getbits_ctrl.sv | 171 +++++++++++++++++
 tb/tb_getbits_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/getbits_ctrl.sv
// Bit-reader front end: serves N-bit requests from the flushbuffer window and consumes them in <=MAX_CHUNK flushes.
// Optional peek (non-consuming) requests via GETBITS_SHOWBITS_EN, which adds the req_peek port.
module getbits_ctrl #(
    parameter int MAX_CHUNK = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [5:0]  req_n,
`ifdef GETBITS_SHOWBITS_EN
    input  logic        req_peek,
`endif
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        err,
    output logic        fb_in_valid,
    output logic [31:0] fb_n,
    input  logic        fb_loading,
    input  logic        fb_done,
    input  logic [31:0] fb_ld_bfr
);
    // state  | meaning
    // PRIME  | zero-length flush after reset so the window fills
    // IDLE   | ready for a request
    // ISSUE  | flush command to flushbuffer
    // WSTART | waiting for flushbuffer to start loading
    // WDONE  | waiting for done with loading low, then one cycle to act
    // RESP   | response pulse
    typedef enum logic [2:0] {PRIME, IDLE, ISSUE, WSTART, WDONE, RESP} state_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t        state_q, state_d;
    logic [5:0]    n_left_q;
    logic [31:0]   acc_q;
    logic [TW-1:0] timer_q;
    logic          err_q;
    logic [31:0]   fb_n_q;
    logic          priming_q;
    logic          done_seen_q;

    logic          peek_in;
    logic [5:0]    n_req;
    logic [5:0]    chunk_first;
    logic [5:0]    chunk_next;
    logic          accept;
    logic          finish;
    logic          timeout_hit;

`ifdef GETBITS_SHOWBITS_EN
    assign peek_in = req_peek;
`else
    assign peek_in = 1'b0;
`endif

    assign n_req       = (req_n > 6'd32) ? 6'd32 : req_n;
    assign chunk_first = (n_req > 6'(MAX_CHUNK)) ? 6'(MAX_CHUNK) : n_req;
    assign chunk_next  = (n_left_q > 6'(MAX_CHUNK)) ? 6'(MAX_CHUNK) : n_left_q;
    assign err         = err_q;
    assign fb_n        = fb_n_q;

    // Top k bits of the window, right-justified; k=32 returns the whole word.
    function automatic logic [31:0] top_bits(input logic [31:0] w, input logic [5:0] k);
        if (k == 6'd0) return 32'd0;
        return w >> (6'd32 - k);
    endfunction

    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_data    = 32'd0;
        fb_in_valid = 1'b0;
        accept      = 1'b0;
        finish      = 1'b0;
        timeout_hit = 1'b0;
        // Outputs stay quiet while rst is held, so priming pulses once after release.
        if (!rst) begin
            case (state_q)
                PRIME: begin
                    fb_in_valid = 1'b1;
                    state_d     = WSTART;
                end
                IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        accept  = 1'b1;
                        state_d = (n_req == 6'd0 || peek_in) ? RESP : ISSUE;
                    end
                end
                ISSUE: begin
                    fb_in_valid = 1'b1;
                    state_d     = WSTART;
                end
                WSTART, WDONE: begin
                    if (TIMEOUT != 0 && timer_q == TW'(1)) begin
                        timeout_hit = 1'b1;
                        state_d     = IDLE;
                    end else if (state_q == WSTART) begin
                        if (fb_loading) state_d = WDONE;
                    end else if (done_seen_q) begin
                        finish  = 1'b1;
                        state_d = (n_left_q != 6'd0) ? ISSUE : (priming_q ? IDLE : RESP);
                    end
                end
                RESP: begin
                    rsp_valid = 1'b1;
                    rsp_data  = acc_q;
                    state_d   = IDLE;
                end
                default: state_d = PRIME;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PRIME;
            n_left_q    <= 6'd0;
            acc_q       <= 32'd0;
            timer_q     <= '0;
            err_q       <= 1'b0;
            fb_n_q      <= 32'd0;
            priming_q   <= 1'b1;
            done_seen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                PRIME, ISSUE: begin
                    timer_q     <= TW'(TIMEOUT);
                    done_seen_q <= 1'b0;
                end
                IDLE: begin
                    if (accept) begin
                        if (peek_in) begin
                            acc_q    <= top_bits(fb_ld_bfr, n_req);
                            n_left_q <= 6'd0;
                        end else begin
                            acc_q    <= top_bits(fb_ld_bfr, chunk_first);
                            n_left_q <= n_req - chunk_first;
                            if (n_req != 6'd0) fb_n_q <= 32'(chunk_first);
                        end
                    end
                end
                WSTART, WDONE: begin
                    if (timer_q != '0) timer_q <= timer_q - TW'(1);
                    if (timeout_hit) begin
                        err_q       <= 1'b1;
                        priming_q   <= 1'b0;
                        done_seen_q <= 1'b0;
                    end else if (state_q == WDONE) begin
                        if (fb_done && !fb_loading) done_seen_q <= 1'b1;
                        if (finish) begin
                            done_seen_q <= 1'b0;
                            if (n_left_q != 6'd0) begin
                                acc_q    <= (acc_q << chunk_next) | top_bits(fb_ld_bfr, chunk_next);
                                n_left_q <= n_left_q - chunk_next;
                                fb_n_q   <= 32'(chunk_next);
                            end else begin
                                priming_q <= 1'b0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_getbits_ctrl.sv
// Directed bench for getbits_ctrl with a behavioural flushbuffer stub; peek test built only with GETBITS_SHOWBITS_EN.
module tb_getbits_ctrl;
    localparam logic [255:0] STREAM =
        256'h000001B3_A5C3F01E_12345678_9ABCDEF0_DEADBEEF_CAFEF00D_00000000_00000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [5:0]  req_n = 6'd0;
    logic        req_peek = 1'b0;
    logic        req_ready, rsp_valid, err, fb_in_valid;
    logic [31:0] rsp_data, fb_n;
    logic        fb_loading = 1'b0;
    logic        fb_done = 1'b0;
    logic [31:0] fb_ld_bfr;

    int n_checks = 0;
    int n_errors = 0;

    // flushbuffer stub state
    logic [255:0] stream = STREAM;
    logic         pend = 1'b0;
    int           pend_n = 0, cur_n = 0, ref_left = 0;
    int           refill = 1;
    logic         stall = 1'b0;
    int           flush_cnt = 0;
    int           last_fb_n = -1, prev_fb_n = -1;

    assign fb_ld_bfr = stream[255:224];

    always #5 clk = ~clk;

    getbits_ctrl #(.MAX_CHUNK(16), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_n(req_n),
`ifdef GETBITS_SHOWBITS_EN
        .req_peek(req_peek),
`endif
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err),
        .fb_in_valid(fb_in_valid), .fb_n(fb_n), .fb_loading(fb_loading),
        .fb_done(fb_done), .fb_ld_bfr(fb_ld_bfr)
    );

    // loading rises the cycle after in_valid, lasts `refill` cycles, then done stays high
    always @(negedge clk) begin
        if (rst) begin
            stream = STREAM; pend = 1'b0; fb_loading = 1'b0; fb_done = 1'b0;
        end else begin
            if (fb_loading) begin
                if (ref_left <= 1) begin
                    fb_loading = 1'b0; fb_done = 1'b1; stream = stream << cur_n;
                end else ref_left = ref_left - 1;
            end
            if (pend) begin
                pend = 1'b0;
                if (!stall) begin
                    fb_loading = 1'b1; fb_done = 1'b0; ref_left = refill; cur_n = pend_n;
                end
            end
            if (fb_in_valid) begin
                pend = 1'b1; pend_n = int'(fb_n); flush_cnt = flush_cnt + 1;
                prev_fb_n = last_fb_n; last_fb_n = int'(fb_n);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1; req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_fb_in_valid", 32'(fb_in_valid), 0);
        check("rst_fb_n", fb_n, 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_err", 32'(err), 0);
        rst = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!req_ready && k < 200) begin
            @(negedge clk); k++;
        end
        check({tag, "_ready_to"}, 32'(req_ready), 1);
    endtask

    task automatic do_req(input string tag, input logic [5:0] n, input logic peek,
                          input logic [31:0] exp, input int exp_flushes);
        int f0, k;
        logic seen;
        logic [31:0] got;
        wait_ready(tag);
        f0 = flush_cnt;
        req_n = n; req_peek = peek; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; req_peek = 1'b0;
        seen = 1'b0; got = 32'hDEAD_DEAD; k = 0;
        while (!seen && k < 200) begin
            if (rsp_valid) begin
                seen = 1'b1; got = rsp_data;
            end else begin
                @(negedge clk); k++;
            end
        end
        check({tag, "_rsp_to"}, 32'(seen), 1);
        check(tag, got, exp);
        @(negedge clk);
        check({tag, "_flushes"}, 32'(flush_cnt - f0), 32'(exp_flushes));
    endtask

    initial begin
        int f0, rsp0, k;
        logic [31:0] exp8 [4] = '{32'h00, 32'h00, 32'h01, 32'hB3};

        // reset then prime: one zero-length flush, no response
        do_reset();
        f0 = flush_cnt;
        check("prime_ready_low", 32'(req_ready), 0);
        k = 0;
        while (!req_ready && k < 100) begin
            @(negedge clk);
            if (rsp_valid) check("prime_no_rsp", 32'(rsp_valid), 0);
            k++;
        end
        check("prime_ready", 32'(req_ready), 1);
        check("prime_done_state", {30'd0, fb_done, fb_loading}, 32'b10);
        check("prime_flushes", 32'(flush_cnt - f0), 1);
        check("prime_fb_n", 32'(last_fb_n), 0);

        // 8-bit reads of 0x000001B3
        for (int i = 0; i < 4; i++) begin
            do_req($sformatf("get8_%0d", i), 6'd8, 1'b0, exp8[i], 1);
            check($sformatf("get8_%0d_fb_n", i), 32'(last_fb_n), 8);
        end

        // 32-bit read split 16+16, then the following 12 bits
        do_reset();
        do_req("get32", 6'd32, 1'b0, 32'h0000_01B3, 2);
        check("get32_fb_n_a", 32'(prev_fb_n), 16);
        check("get32_fb_n_b", 32'(last_fb_n), 16);
        do_req("get12", 6'd12, 1'b0, 32'h0000_0A5C, 1);
        check("get12_fb_n", 32'(last_fb_n), 12);

        // zero-length, saturated 40, and 17 (16+1) with slower refill
        do_req("get0", 6'd0, 1'b0, 32'h0, 0);
        do_req("get40", 6'd40, 1'b0, 32'h3F01_E123, 2);
        check("get40_fb_n_b", 32'(last_fb_n), 16);
        refill = 3;
        do_req("get17", 6'd17, 1'b0, 32'h0000_8ACF, 2);
        check("get17_fb_n_a", 32'(prev_fb_n), 16);
        check("get17_fb_n_b", 32'(last_fb_n), 1);
        refill = 1;

        // stalled flushbuffer: timeout after 16 waiting cycles following ISSUE
        stall = 1'b1;
        wait_ready("stall");
        rsp0 = 0;
        req_n = 6'd8; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("stall_issue", 32'(fb_in_valid), 1);
        k = 0;
        while (!err && k < 64) begin
            @(negedge clk); k++;
            if (rsp_valid) rsp0++;
        end
        check("timeout_err", 32'(err), 1);
        check("timeout_cycles", 32'(k), 17);
        check("timeout_idle", 32'(req_ready), 1);
        repeat (3) @(negedge clk);
        check("timeout_no_rsp", 32'(rsp0), 0);
        check("err_sticky", 32'(err), 1);
        stall = 1'b0;

        do_reset();
        f0 = flush_cnt;
        wait_ready("reprime");
        check("reprime_err", 32'(err), 0);
        check("reprime_flushes", 32'(flush_cnt - f0), 1);
        do_req("reprime_get8", 6'd8, 1'b0, 32'h00, 1);

`ifdef GETBITS_SHOWBITS_EN
        do_reset();
        do_req("peek16_a", 6'd16, 1'b1, 32'h0, 0);
        do_req("peek16_b", 6'd16, 1'b1, 32'h0, 0);
        do_req("peek_get32", 6'd32, 1'b0, 32'h0000_01B3, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
